// File: rtl/stack_frame_pkg.sv
// -----------------------------------------------------------------------------
// stack_frame_pkg
// Shared definitions for the stack frame engine:
//   cmd_op_e    - command opcode encodings carried on i_cmd_op
//   state_e     - sequencer states (IDLE, PUSH, POP_RD, POP_WB, DONE)
//   op_is_legal - true for the five defined opcodes
// -----------------------------------------------------------------------------
package stack_frame_pkg;

    typedef enum logic [2:0] {
        OP_PUSH1   = 3'b000,
        OP_POP1    = 3'b001,
        OP_SAVE    = 3'b010,
        OP_RESTORE = 3'b011,
        OP_ADJUST  = 3'b100
    } cmd_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PUSH,
        S_POP_RD,
        S_POP_WB,
        S_DONE
    } state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= 3'(OP_ADJUST));
    endfunction

endpackage

// File: rtl/stack_frame_sp_unit.sv
// -----------------------------------------------------------------------------
// stack_frame_sp_unit
// Owns the stack pointer register, its +/-STEP adders, the ADJUST adder and
// the bound comparators used to vet a whole command at accept time.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_op                opcode of the command being offered (for bound check)
//   i_offset            ADJUST signed offset
//   i_dec / i_inc       step SP down / up by STEP this cycle
//   i_load              load the ADJUST result this cycle
//   o_sp                current SP
//   o_sp_dec/_dec2/_inc SP-STEP, SP-2*STEP, SP+STEP
//   o_ovf / o_unf       final SP of the offered command out of bounds
// -----------------------------------------------------------------------------
module stack_frame_sp_unit
    import stack_frame_pkg::*;
#(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 16,
    parameter int                NREGS       = 4,
    parameter int                STEP        = 2,
    parameter logic [ADDR_W-1:0] SP_RESET    = 16'h0800,
    parameter logic [ADDR_W-1:0] STACK_LIMIT = 16'h0400
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_offset,
    input  logic              i_dec,
    input  logic              i_inc,
    input  logic              i_load,
    output logic [ADDR_W-1:0] o_sp,
    output logic [ADDR_W-1:0] o_sp_dec,
    output logic [ADDR_W-1:0] o_sp_dec2,
    output logic [ADDR_W-1:0] o_sp_inc,
    output logic              o_ovf,
    output logic              o_unf
);

    localparam logic signed [ADDR_W:0] L_STEP  = (ADDR_W+1)'(STEP);
    localparam logic signed [ADDR_W:0] L_FRAME = (ADDR_W+1)'(STEP * (NREGS + 1));
    localparam logic signed [ADDR_W:0] L_LIMIT = {1'b0, STACK_LIMIT};
    localparam logic signed [ADDR_W:0] L_TOP   = {1'b0, SP_RESET};

    logic [ADDR_W-1:0]        r_sp;
    logic signed [ADDR_W:0]   w_delta;
    logic signed [ADDR_W:0]   w_final;

    // Net SP movement of the whole command, so a burst is either fully
    // legal or rejected before any memory traffic.
    always_comb begin
        w_delta = '0;
        case (i_op)
            OP_PUSH1:   w_delta = -L_STEP;
            OP_POP1:    w_delta = L_STEP;
            OP_SAVE:    w_delta = -L_FRAME;
            OP_RESTORE: w_delta = L_FRAME;
            OP_ADJUST:  w_delta = (ADDR_W+1)'($signed(i_offset));
            default:    w_delta = '0;
        endcase
    end

    // One extra bit: going below address 0 shows up as negative, i.e. overflow.
    assign w_final = $signed({1'b0, r_sp}) + w_delta;
    assign o_ovf   = (w_final < L_LIMIT);
    assign o_unf   = (w_final > L_TOP);

    assign o_sp      = r_sp;
    assign o_sp_dec  = r_sp - ADDR_W'(STEP);
    assign o_sp_dec2 = r_sp - ADDR_W'(2 * STEP);
    assign o_sp_inc  = r_sp + ADDR_W'(STEP);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sp <= SP_RESET;
        end else if (i_load) begin
            r_sp <= w_final[ADDR_W-1:0];
        end else if (i_dec) begin
            r_sp <= o_sp_dec;
        end else if (i_inc) begin
            r_sp <= o_sp_inc;
        end
    end

endmodule

// File: rtl/stack_frame_engine.sv
// -----------------------------------------------------------------------------
// stack_frame_engine
// Sequences single-word push/pop, full frame SAVE/RESTORE and SP ADJUST
// against a single-port stack memory.
// Ports:
//   i_clk, i_rst                       clock, asynchronous active-high reset
//   i_cmd_valid/o_cmd_ready            command handshake (ready only in IDLE)
//   i_cmd_op, i_cmd_data, i_cmd_dst    opcode, push word / adjust offset, pop dest
//   i_ret_pc, i_reg_snap               SAVE inputs (reg i at [i*DATA_W +: DATA_W])
//   o_mem_addr/_wdata/_we/_re          stack memory port
//   i_mem_rdata                        read data, valid the cycle after o_mem_re
//   o_wb_valid/_idx/_data              register writeback (idx==NREGS is PC)
//   o_sp                               current stack pointer
//   o_done, o_fault_ovf/_unf/_ill      one-cycle pulses in the DONE cycle
// -----------------------------------------------------------------------------
module stack_frame_engine
    import stack_frame_pkg::*;
#(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 16,
    parameter int                NREGS       = 4,
    parameter int                STEP        = 2,
    parameter logic [ADDR_W-1:0] SP_RESET    = 16'h0800,
    parameter logic [ADDR_W-1:0] STACK_LIMIT = 16'h0400,
    localparam int               IDX_W       = $clog2(NREGS + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic [2:0]              i_cmd_op,
    input  logic [DATA_W-1:0]       i_cmd_data,
    input  logic [IDX_W-1:0]        i_cmd_dst,
    input  logic [DATA_W-1:0]       i_ret_pc,
    input  logic [NREGS*DATA_W-1:0] i_reg_snap,
    output logic [ADDR_W-1:0]       o_mem_addr,
    output logic [DATA_W-1:0]       o_mem_wdata,
    output logic                    o_mem_we,
    output logic                    o_mem_re,
    input  logic [DATA_W-1:0]       i_mem_rdata,
    output logic                    o_wb_valid,
    output logic [IDX_W-1:0]        o_wb_idx,
    output logic [DATA_W-1:0]       o_wb_data,
    output logic [ADDR_W-1:0]       o_sp,
    output logic                    o_done,
    output logic                    o_fault_ovf,
    output logic                    o_fault_unf,
    output logic                    o_fault_ill
);

    state_e              r_state;
    logic [DATA_W-1:0]   r_regs [NREGS];
    logic [IDX_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_ptr;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_mem_we;
    logic                r_mem_re;
    logic                r_wb_valid;
    logic [IDX_W-1:0]    r_wb_idx;
    logic                r_done;
    logic                r_fault_ovf;
    logic                r_fault_unf;
    logic                r_fault_ill;

    logic                w_accept;
    logic                w_legal;
    logic                w_ovf;
    logic                w_unf;
    logic                w_sp_load;
    logic [ADDR_W-1:0]   w_sp;
    logic [ADDR_W-1:0]   w_sp_dec;
    logic [ADDR_W-1:0]   w_sp_dec2;
    logic [ADDR_W-1:0]   w_sp_inc;

    assign o_cmd_ready = (r_state == S_IDLE);
    assign w_accept    = i_cmd_valid && o_cmd_ready;
    assign w_legal     = op_is_legal(i_cmd_op);
    assign w_sp_load   = w_accept && (i_cmd_op == 3'(OP_ADJUST)) && !w_ovf && !w_unf;

    stack_frame_sp_unit #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .NREGS       (NREGS),
        .STEP        (STEP),
        .SP_RESET    (SP_RESET),
        .STACK_LIMIT (STACK_LIMIT)
    ) u_sp (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_op      (i_cmd_op),
        .i_offset  (i_cmd_data),
        .i_dec     (r_state == S_PUSH),
        .i_inc     (r_state == S_POP_WB),
        .i_load    (w_sp_load),
        .o_sp      (w_sp),
        .o_sp_dec  (w_sp_dec),
        .o_sp_dec2 (w_sp_dec2),
        .o_sp_inc  (w_sp_inc),
        .o_ovf     (w_ovf),
        .o_unf     (w_unf)
    );

    // SP only moves at the end of each PUSH/POP_WB cycle, so the address
    // registered for the following word is one more step ahead.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_ptr       <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_wb_idx    <= '0;
            r_done      <= 1'b0;
            r_fault_ovf <= 1'b0;
            r_fault_unf <= 1'b0;
            r_fault_ill <= 1'b0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_done      <= 1'b0;
            r_fault_ovf <= 1'b0;
            r_fault_unf <= 1'b0;
            r_fault_ill <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (!w_legal) begin
                            r_fault_ill <= 1'b1;
                            r_done      <= 1'b1;
                            r_state     <= S_DONE;
                        end else if (w_ovf) begin
                            r_fault_ovf <= 1'b1;
                            r_done      <= 1'b1;
                            r_state     <= S_DONE;
                        end else if (w_unf) begin
                            r_fault_unf <= 1'b1;
                            r_done      <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            case (i_cmd_op)
                                OP_PUSH1: begin
                                    r_state     <= S_PUSH;
                                    r_mem_we    <= 1'b1;
                                    r_mem_addr  <= w_sp_dec;
                                    r_mem_wdata <= i_cmd_data;
                                    r_cnt       <= '0;
                                end
                                OP_SAVE: begin
                                    r_state     <= S_PUSH;
                                    r_mem_we    <= 1'b1;
                                    r_mem_addr  <= w_sp_dec;
                                    r_mem_wdata <= i_ret_pc;
                                    r_cnt       <= IDX_W'(NREGS);
                                    for (int unsigned i = 0; i < NREGS; i++) begin
                                        r_regs[i] <= i_reg_snap[i*DATA_W +: DATA_W];
                                    end
                                end
                                OP_POP1: begin
                                    r_state    <= S_POP_RD;
                                    r_mem_re   <= 1'b1;
                                    r_mem_addr <= w_sp;
                                    r_ptr      <= i_cmd_dst;
                                    r_cnt      <= '0;
                                end
                                OP_RESTORE: begin
                                    r_state    <= S_POP_RD;
                                    r_mem_re   <= 1'b1;
                                    r_mem_addr <= w_sp;
                                    r_ptr      <= IDX_W'(NREGS - 1);
                                    r_cnt      <= IDX_W'(NREGS);
                                end
                                default: begin
                                    // ADJUST: SP is loaded by the sp unit this cycle.
                                    r_done  <= 1'b1;
                                    r_state <= S_DONE;
                                end
                            endcase
                        end
                    end
                end
                S_PUSH: begin
                    if (r_cnt != '0) begin
                        r_mem_addr  <= w_sp_dec2;
                        r_mem_wdata <= r_regs[0];
                        r_cnt       <= r_cnt - 1'b1;
                        // Registers are consumed from index 0 upward.
                        for (int unsigned i = 0; i + 1 < NREGS; i++) begin
                            r_regs[i] <= r_regs[i+1];
                        end
                    end else begin
                        r_mem_we <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_POP_RD: begin
                    r_mem_re   <= 1'b0;
                    r_wb_valid <= 1'b1;
                    r_wb_idx   <= r_ptr;
                    r_state    <= S_POP_WB;
                end
                S_POP_WB: begin
                    r_wb_valid <= 1'b0;
                    if (r_cnt != '0) begin
                        r_mem_re   <= 1'b1;
                        r_mem_addr <= w_sp_inc;
                        r_cnt      <= r_cnt - 1'b1;
                        // After reg 0 the last word popped is the PC slot.
                        r_ptr      <= (r_ptr == '0) ? IDX_W'(NREGS) : r_ptr - 1'b1;
                        r_state    <= S_POP_RD;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_we    = r_mem_we;
    assign o_mem_re    = r_mem_re;
    assign o_wb_valid  = r_wb_valid;
    assign o_wb_idx    = r_wb_idx;
    // Read data arrives in the POP_WB cycle itself, so it is forwarded.
    assign o_wb_data   = r_wb_valid ? i_mem_rdata : '0;
    assign o_sp        = w_sp;
    assign o_done      = r_done;
    assign o_fault_ovf = r_fault_ovf;
    assign o_fault_unf = r_fault_unf;
    assign o_fault_ill = r_fault_ill;

endmodule

// File: doc/stack_frame_engine.md
STACK_FRAME_ENGINE -- requirements
Module: stack_frame_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 16, datapath word width.
REQ-002 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-003 SHALL have parameter NREGS, default 4, number of general registers saved per frame.
REQ-004 SHALL have parameter STEP, default 2, SP change per word.
REQ-005 SHALL have parameter SP_RESET, default 16'h0800, empty-stack SP value.
REQ-006 SHALL have parameter STACK_LIMIT, default 16'h0400, lowest legal SP.
REQ-007 SHALL have local constant IDX_W = $clog2(NREGS+1).
REQ-008 CLK  in  1  single clock, rising edge.
REQ-009 Reset  in  1  asynchronous, active-high reset.
REQ-010 cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
REQ-011 cmd_op  in  3  000 PUSH1, 001 POP1, 010 SAVE, 011 RESTORE, 100 ADJUST; others illegal.
REQ-012 cmd_data  in  DATA_W  PUSH1 word, or ADJUST signed offset.
REQ-013 cmd_dst  in  IDX_W  POP1 destination index.
REQ-014 ret_pc  in  DATA_W  return PC for SAVE.
REQ-015 reg_snap  in  NREGS*DATA_W  flattened register file, reg i at bits [i*DATA_W +: DATA_W].
REQ-016 mem_addr, mem_wdata, mem_we, mem_re  out  ADDR_W, DATA_W, 1, 1  stack memory port.
REQ-017 mem_rdata  in  DATA_W  read data, valid the cycle after mem_re.
REQ-018 wb_valid, wb_idx, wb_data  out  1, IDX_W, DATA_W  register writeback; wb_idx==NREGS means PC.
REQ-019 sp  out  ADDR_W  current stack pointer.
REQ-020 done, fault_ovf, fault_unf, fault_ill  out  1 each  one-cycle completion and error pulses.

Function
REQ-021 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on a cycle where cmd_valid && cmd_ready.
REQ-022 On accept, cmd_data, cmd_dst, ret_pc and reg_snap SHALL be latched; later input changes SHALL NOT affect the burst.
REQ-023 States SHALL be IDLE, PUSH, POP_RD, POP_WB, DONE; DONE SHALL last one cycle, assert done, and return to IDLE.
REQ-024 Push word SHALL be pre-decrement: mem_addr = sp-STEP, mem_we=1, sp <= sp-STEP, one word per cycle.
REQ-025 Pop word SHALL take two cycles: POP_RD drives mem_re=1 with mem_addr=sp; POP_WB drives wb_valid=1 with mem_rdata and sp <= sp+STEP.
REQ-026 PUSH1 SHALL push cmd_data; 1 PUSH cycle then DONE.
REQ-027 POP1 SHALL pop one word to wb_idx=cmd_dst.
REQ-028 SAVE SHALL push ret_pc, then reg 0..NREGS-1; NREGS+1 PUSH cycles.
REQ-029 RESTORE SHALL pop reg NREGS-1..0, then PC (wb_idx=NREGS); 2*(NREGS+1) cycles before DONE.
REQ-030 ADJUST SHALL set sp <= sp + sign-extended cmd_data in the accept cycle, then DONE; no memory access.
REQ-031 Bounds SHALL be checked atomically at accept: a final SP < STACK_LIMIT SHALL pulse fault_ovf; a final SP > SP_RESET SHALL pulse fault_unf; in both cases no memory access, SP unchanged, go to DONE.
REQ-032 Illegal cmd_op SHALL pulse fault_ill, with no side effects, and go to DONE.
REQ-033 SP arithmetic SHALL be ADDR_W-bit; bound comparison SHALL be done in ADDR_W+1 bits so wrap below 0 reads as overflow.
REQ-034 mem_we, mem_re and wb_valid SHALL never be asserted in the same cycle.

Reset
REQ-035 Reset SHALL force IDLE, sp=SP_RESET, and all strobes, pulses and wb/mem outputs to 0, asynchronously.
REQ-036 Reset mid-burst SHALL abort the burst; words already written stay in memory; cmd_ready=1 in the first cycle after Reset deasserts.

Structure
REQ-037 Package stack_frame_pkg SHALL hold the cmd_op encodings and the state enum.
REQ-038 Sub-module stack_frame_sp_unit SHALL hold the SP register, the +/-STEP and ADJUST adders, and the bound comparators.

Verification (NREGS=4, STEP=2, SP_RESET=0x0800, STACK_LIMIT=0x0400)
REQ-039 PUSH1 0x0001 -> single mem_we at 0x07FE with data 0x0001; sp=0x07FE; done next cycle.
REQ-040 SAVE with ret_pc=0x0008, regs={1,2,3,4} from sp=0x0800 -> writes 0x07FE=0x0008, 0x07FC=1, 0x07FA=2, 0x07F8=3, 0x07F6=4; sp=0x07F6.
REQ-041 RESTORE right after -> wb (3,4), (2,3), (1,2), (0,1), (4,0x0008); sp=0x0800; done after 10 cycles.
REQ-042 POP1 at sp=0x0800 -> fault_unf pulse; no mem_re; sp stays 0x0800.
REQ-043 ADJUST 0xFFFE -> sp=0x07FE; ADJUST 0xFC00 from 0x0800 -> sp=0x0400 (legal); ADJUST 0xFBFE from 0x0800 -> fault_ovf.
REQ-044 Reset asserted during the third SAVE write -> sp=0x0800, IDLE, no further mem_we.
